fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage: owns the PC, fetches one instruction per request from instruction memory over a req/gnt/rvalid
//  handshake, and drives the IF/ID signals consumed by the decode stage (PC_pype0, PCp4_pype0, Instraction_pype).
//  fetch_nop feeds decode's nop input whenever no valid instruction is delivered.
//  Accepts branch/jump redirects from EX/MEM and stalls from the hazard unit (keep).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset release
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) driven on Instraction_pype
// PORTS
//  clk               in   1   single clock; all state on posedge
//  rst               in   1   asynchronous, active-low reset
//  keep              in   1   stall: hold IF/ID outputs and PC
//  redirect          in   1   taken branch/jump; overrides keep
//  redirect_pc       in   32  new fetch PC; bits [1:0] forced to 0
//  imem_req          out  1   fetch request valid
//  imem_addr         out  32  fetch address (= pc_q)
//  imem_gnt          in   1   request accepted this cycle
//  imem_rvalid       in   1   response valid (one per accepted request, >=1 cycle after gnt)
//  imem_rdata        in   32  instruction word
//  PC_pype0          out  32  PC of delivered instruction
//  PCp4_pype0        out  32  PC_pype0 + 4
//  Instraction_pype  out  32  delivered instruction, NOP_INSTR on bubble
//  fetch_nop         out  1   1 = bubble
// BEHAVIOUR
//  Reset (async, rst=0): pc_q=RESET_PC, state=REQ, PC_pype0=0, PCp4_pype0=0, Instraction_pype=NOP_INSTR,
//   fetch_nop=1, skid buffer empty; imem_req=0 while rst=0. Reset mid-transaction drops any in-flight response.
//  Max one outstanding request. imem_req = (state==REQ) && rst; imem_addr = pc_q (combinational).
//  States:
//   REQ : redirect -> pc_q<=redirect_pc; if gnt that cycle -> DROP else stay REQ.
//         gnt & !redirect -> WAIT.
//   WAIT: redirect & !rvalid -> pc_q<=redirect_pc, DROP.
//         redirect & rvalid -> discard data, pc_q<=redirect_pc, REQ.
//         rvalid & !keep -> deliver (see below), pc_q<=pc_q+4, REQ.
//         rvalid & keep  -> store {pc_q,rdata} in skid buffer, HOLD.
//   HOLD: redirect -> discard buffer, pc_q<=redirect_pc, REQ.
//         !keep -> deliver buffer, pc_q<=pc_q+4, REQ. keep -> stay.
//   DROP: rvalid -> discard, REQ. redirect -> pc_q<=redirect_pc (stay until rvalid).
//  Deliver: PC_pype0<=pc, PCp4_pype0<=pc+4, Instraction_pype<=data, fetch_nop<=0 (registered, 1-cycle).
//  Output registers each cycle, priority: redirect > keep > deliver > bubble.
//   redirect: Instraction_pype<=NOP_INSTR, fetch_nop<=1, PC outputs hold.
//   keep (no redirect): all outputs hold.
//   bubble (no deliver, !keep): Instraction_pype<=NOP_INSTR, fetch_nop<=1, PC outputs hold.
//  Best-case throughput: one instruction per 2 cycles (REQ->WAIT with rvalid 1 cycle after gnt).
//  Arithmetic: pc+4 is 32-bit modulo (0xFFFF_FFFC -> 0x0000_0000), no flag.
//  Never deliver a response belonging to a pre-redirect PC.
// STRUCTURE
//  define.v gets: `FETCH_REQ/`FETCH_WAIT/`FETCH_HOLD/`FETCH_DROP (2-bit) and `INSTR_NOP 32'h0000_0013.
//  Flat module, no sub-module; skid buffer is one 64-bit register + valid implied by HOLD state.
// TESTING
//  1 rst low 3 cycles, release, gnt=1, rvalid 1 cycle later -> imem_addr 0,4,8...; outputs PC 0/4, 4/8; fetch_nop=0 on deliver.
//  2 rvalid arrives with keep=1 for 3 cycles -> outputs frozen, imem_req=0; keep drop -> buffered instr delivered next edge, pc_q+4.
//  3 redirect(0x100) in WAIT, rvalid 2 cycles later with stale data -> stale word never on Instraction_pype; next imem_addr=0x100.
//  4 redirect(0x203) coincident with rvalid -> data discarded, fetch_nop=1, next imem_addr=0x200.
//  5 redirect & keep same cycle in HOLD -> buffer dropped, Instraction_pype=0x0000_0013, next req at redirect_pc.
//  6 RESET_PC=0xFFFF_FFFC: first deliver PCp4_pype0=0, second imem_addr=0; rst asserted in WAIT -> async return to reset values.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared types and helpers for the instruction fetch stage.
//   - fetch_state_e : fetch controller state encoding (2 bits)
//   - fetch_entry_t : one fetched instruction paired with its PC
//   - INSTR_NOP     : bubble encoding (addi x0,x0,0)
//   - pc_align      : clears the two low PC bits (word-aligned fetch)
//   - pc_next       : sequential successor PC, 32-bit wrap-around
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,  // presenting a request to instruction memory
    FETCH_WAIT = 2'd1,  // request granted, waiting for its response
    FETCH_HOLD = 2'd2,  // response captured in the skid buffer while stalled
    FETCH_DROP = 2'd3   // waiting for a response that must be thrown away
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Plain 32-bit add: 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage. Owns the PC, fetches one instruction per request over a
//   req/gnt/rvalid instruction-memory handshake and drives the IF/ID
//   registers consumed by decode. At most one request is outstanding.
//
//   Handshake: imem_req is a valid that is held, with imem_addr stable, until
//   the cycle imem_gnt is seen high; req&gnt on one posedge is the transfer.
//   Exactly one imem_rvalid pulse follows each granted request, no earlier
//   than the cycle after the grant. rvalid is never back-pressured: a
//   response arriving during a stall is parked in a one-entry skid buffer.
//
// Ports
//   clk              : clock, all state on posedge
//   rst              : asynchronous active-low reset
//   keep             : stall from hazard unit, holds IF/ID outputs and PC
//   redirect         : taken branch/jump, overrides keep
//   redirect_pc      : new fetch PC (low two bits ignored)
//   imem_req         : fetch request valid
//   imem_addr        : fetch address (current PC)
//   imem_gnt         : request accepted this cycle
//   imem_rvalid      : response valid
//   imem_rdata       : response instruction word
//   PC_pype0         : PC of delivered instruction
//   PCp4_pype0       : PC_pype0 + 4
//   Instraction_pype : delivered instruction, NOP_INSTR on a bubble
//   fetch_nop        : 1 = bubble (feeds decode's nop input)
//   dbg_state        : current fetch controller state
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        fetch_nop,
  output logic [1:0]  dbg_state
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  redirect_target;

  // Skid buffer: its contents are only meaningful while state_q == FETCH_HOLD.
  fetch_entry_t skid_q;
  logic         skid_load;

  // One-cycle delivery strobe into the IF/ID registers.
  logic         deliver;
  fetch_entry_t deliver_entry;

  assign redirect_target = pc_align(redirect_pc);

  // -------------------------------------------------------------------------
  // State register (state, PC, skid buffer)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= '{pc: pc_q, instr: imem_rdata};
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  //   A redirect always wins. If it lands while a response is still owed
  //   (grant taken this cycle, or waiting without rvalid) we go to DROP so the
  //   stale word is swallowed instead of being mistaken for the new target.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_load     = 1'b0;
    deliver       = 1'b0;
    deliver_entry = '{pc: pc_q, instr: imem_rdata};

    unique case (state_q)
      FETCH_REQ: begin
        if (redirect) begin
          pc_d = redirect_target;
          if (imem_gnt) begin
            state_d = FETCH_DROP;
          end
        end else if (imem_gnt) begin
          state_d = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
        end else if (imem_rvalid) begin
          if (!keep) begin
            deliver       = 1'b1;
            deliver_entry = '{pc: pc_q, instr: imem_rdata};
            pc_d          = pc_next(pc_q);
            state_d       = FETCH_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = FETCH_REQ;
        end else if (!keep) begin
          deliver       = 1'b1;
          deliver_entry = skid_q;
          pc_d          = pc_next(pc_q);
          state_d       = FETCH_REQ;
        end
      end

      FETCH_DROP: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_rvalid) begin
          state_d = FETCH_REQ;
        end
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state_q == FETCH_REQ) && rst;
    imem_addr = pc_q;
    dbg_state = state_q;
  end

  // -------------------------------------------------------------------------
  // IF/ID registers. Priority: redirect > keep > deliver > bubble.
  // PC outputs are left untouched on bubbles so decode sees a stable value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_pype0         <= '0;
      PCp4_pype0       <= '0;
      Instraction_pype <= NOP_INSTR;
      fetch_nop        <= 1'b1;
    end else if (redirect) begin
      Instraction_pype <= NOP_INSTR;
      fetch_nop        <= 1'b1;
    end else if (!keep) begin
      if (deliver) begin
        PC_pype0         <= deliver_entry.pc;
        PCp4_pype0       <= pc_next(deliver_entry.pc);
        Instraction_pype <= deliver_entry.instr;
        fetch_nop        <= 1'b0;
      end else begin
        Instraction_pype <= NOP_INSTR;
        fetch_nop        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Two instances share the stimulus inputs:
//   u_dut (RESET_PC 0) and u_dut2 (RESET_PC 0xFFFF_FFFC); whichever is not in
//   use is held in reset and sel picks which outputs are observed.
//   Stimulus pushes {pc, pc+4, instr} into exp_q when it hands the DUT a
//   response that must be delivered; the monitor pops on every fresh delivery.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst1;
  logic        rst2;
  logic        keep;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req1, req2;
  logic [31:0] addr1, addr2;
  logic [31:0] pc0_1, pc0_2;
  logic [31:0] pcp4_1, pcp4_2;
  logic [31:0] instr_1, instr_2;
  logic        nop_1, nop_2;
  logic [1:0]  dbg1, dbg2;

  logic        sel;
  logic        req_m;
  logic [31:0] addr_m;
  logic [31:0] pc0_m;
  logic [31:0] pcp4_m;
  logic [31:0] instr_m;
  logic        nop_m;
  logic [1:0]  dbg_m;

  int checks   = 0;
  int failures = 0;
  logic [95:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst1), .keep(keep), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PC_pype0(pc0_1), .PCp4_pype0(pcp4_1),
    .Instraction_pype(instr_1), .fetch_nop(nop_1), .dbg_state(dbg1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst2), .keep(keep), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PC_pype0(pc0_2), .PCp4_pype0(pcp4_2),
    .Instraction_pype(instr_2), .fetch_nop(nop_2), .dbg_state(dbg2)
  );

  assign req_m   = sel ? req2    : req1;
  assign addr_m  = sel ? addr2   : addr1;
  assign pc0_m   = sel ? pc0_2   : pc0_1;
  assign pcp4_m  = sel ? pcp4_2  : pcp4_1;
  assign instr_m = sel ? instr_2 : instr_1;
  assign nop_m   = sel ? nop_2   : nop_1;
  assign dbg_m   = sel ? dbg2    : dbg1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change one time unit after the falling edge, far from posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One complete fetch from REQ: grant, lat cycles later respond, expect delivery.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] pcp4,
                       input logic [31:0] data, input int lat);
    #1;
    chk("req_high", {31'd0, req_m}, 32'd1);
    chk("req_addr", addr_m, addr);
    keep      = 1'b0;
    redirect  = 1'b0;
    imem_gnt  = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (lat - 1) begin
      chk("wait_req_low", {31'd0, req_m}, 32'd0);
      tick();
    end
    chk("wait_req_low", {31'd0, req_m}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back({addr, pcp4, data});
    tick();
    imem_rvalid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic        k;
    logic [95:0] e;
    k = keep;
    #1;
    if (!nop_m) begin
      // With keep high the registers just hold the previous delivery.
      if (!k) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_deliver: got pc %h instr %h, expected no delivery", pc0_m, instr_m);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc",    pc0_m,   e[95:64]);
          chk("deliver_pcp4",  pcp4_m,  e[63:32]);
          chk("deliver_instr", instr_m, e[31:0]);
        end
      end
    end else begin
      chk("bubble_instr", instr_m, INSTR_NOP);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    keep = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset held for three cycles
    repeat (3) begin
      tick();
      chk("rst_req",   {31'd0, req_m}, 32'd0);
      chk("rst_nop",   {31'd0, nop_m}, 32'd1);
      chk("rst_pc",    pc0_m,  32'd0);
      chk("rst_pcp4",  pcp4_m, 32'd0);
      chk("rst_instr", instr_m, 32'h0000_0013);
      chk("rst_state", {30'd0, dbg_m}, 32'd0);
      chk("rst_addr",  addr_m, 32'd0);
    end
    rst1 = 1'b1;

    // 1: sequential fetches 0,4,8
    fetch(32'h0000_0000, 32'h0000_0004, 32'h0010_0093, 1);
    fetch(32'h0000_0004, 32'h0000_0008, 32'h0020_0113, 1);
    fetch(32'h0000_0008, 32'h0000_000C, 32'h0030_0193, 2);

    // 2: response lands during a stall, parked, delivered on release
    chk("t2_addr", addr_m, 32'h0000_000C);
    imem_gnt = 1'b1; keep = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
    tick();
    imem_rvalid = 1'b0;
    repeat (2) begin
      chk("hold_req",   {31'd0, req_m}, 32'd0);
      chk("hold_pc",    pc0_m,   32'h0000_0008);
      chk("hold_instr", instr_m, 32'h0030_0193);
      chk("hold_nop",   {31'd0, nop_m}, 32'd0);
      chk("hold_state", {30'd0, dbg_m}, 32'd2);
      tick();
    end
    keep = 1'b0;
    exp_q.push_back({32'h0000_000C, 32'h0000_0010, 32'h0040_0213});
    tick();
    chk("t2_next_addr", addr_m, 32'h0000_0010);

    // 3: redirect in WAIT, stale response arrives two cycles later
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("t3_drop_req", {31'd0, req_m}, 32'd0);
    chk("t3_state",    {30'd0, dbg_m}, 32'd3);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    fetch(32'h0000_0100, 32'h0000_0104, 32'h0050_0293, 1);

    // 4: redirect to unaligned 0x203 together with rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    imem_rvalid = 1'b0; redirect = 1'b0;
    chk("t4_nop",   {31'd0, nop_m}, 32'd1);
    chk("t4_instr", instr_m, 32'h0000_0013);
    fetch(32'h0000_0200, 32'h0000_0204, 32'h0060_0313, 2);

    // 5: redirect and keep together while HOLD
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002; keep = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0; keep = 1'b0;
    chk("t5_instr", instr_m, 32'h0000_0013);
    chk("t5_nop",   {31'd0, nop_m}, 32'd1);
    fetch(32'h0000_0300, 32'h0000_0304, 32'h0070_0393, 1);

    // 5b: redirect in REQ with grant the same cycle
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    imem_gnt = 1'b0; redirect = 1'b0;
    chk("t5b_drop_req", {31'd0, req_m}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_rvalid = 1'b0;
    fetch(32'h0000_0400, 32'h0000_0404, 32'h0080_0413, 1);

    // 5c: redirect in REQ without grant
    redirect = 1'b1; redirect_pc = 32'h0000_0502;
    tick();
    redirect = 1'b0;
    fetch(32'h0000_0500, 32'h0000_0504, 32'h0090_0493, 1);

    // 6: wrap-around instance and asynchronous reset in WAIT
    tick();
    sel = 1'b1; rst1 = 1'b0; rst2 = 1'b1;
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 32'h00A0_0513, 1);
    chk("t6_pc",   pc0_m,  32'hFFFF_FFFC);
    chk("t6_pcp4", pcp4_m, 32'h0000_0000);
    chk("t6_addr", addr_m, 32'h0000_0000);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("t6_wait_state", {30'd0, dbg_m}, 32'd1);
    rst2 = 1'b0;
    #1;
    chk("t6_rst_req",   {31'd0, req_m}, 32'd0);
    chk("t6_rst_addr",  addr_m, 32'hFFFF_FFFC);
    chk("t6_rst_pc",    pc0_m,  32'd0);
    chk("t6_rst_pcp4",  pcp4_m, 32'd0);
    chk("t6_rst_instr", instr_m, 32'h0000_0013);
    chk("t6_rst_nop",   {31'd0, nop_m}, 32'd1);
    chk("t6_rst_state", {30'd0, dbg_m}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0004;
    tick();
    imem_rvalid = 1'b0;
    rst2 = 1'b1;
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 32'h00B0_0593, 1);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
